calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Sequencer that drives one operand to the sin/cos/sqrt/prime units, waits for them to settle,
// and captures their digits into a display result; supports single ops and a four-step scan.
module calc_sequencer #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned DWELL_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op,
  input  logic [8:0]  num_in,
  output logic [8:0]  unit_num,
  input  logic [15:0] sin_dig,
  input  logic        sin_sign,
  input  logic [11:0] cos_dig,
  input  logic        cos_sign,
  input  logic [19:0] sqrt_dig,
  input  logic        is_prime,
  output logic [19:0] res_dig,
  output logic        res_sign,
  output logic [1:0]  res_op,
  output logic        res_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] SettleLd = 4'(SETTLE_CYC);
  localparam logic [7:0] DwellLd  = 8'(DWELL_CYC);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDwell} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_settle_cnt;
  logic [7:0]  r_dwell_cnt;
  logic [1:0]  r_fn;
  logic        r_scan;
  logic [8:0]  r_unit;
  logic [19:0] r_res_dig;
  logic        r_res_sign;
  logic [1:0]  r_res_op;
  logic        r_res_valid;
  logic        r_err;

  logic        w_req;
  logic        w_accept;
  logic        w_illegal;
  logic        w_load_settle;
  logic        w_load_dwell;
  logic [19:0] w_cap_dig;
  logic        w_cap_sign;

  // Abort wins over start in IDLE, so neither accept nor err fires.
  assign w_req     = (r_state == StIdle) && start && !abort;
  assign w_accept  = w_req && (op <= 3'd4);
  assign w_illegal = w_req && (op >= 3'd5);

  assign w_load_settle = (w_state_nxt == StSettle) && (r_state != StSettle);
  assign w_load_dwell  = (w_state_nxt == StDwell) && (r_state != StDwell);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = StSettle;
      end
      StSettle: begin
        if (abort) begin
          w_state_nxt = StIdle;
        end else if (r_settle_cnt <= 4'd1) begin
          w_state_nxt = StCapture;
        end
      end
      StCapture: begin
        // Capture itself still completes this cycle even when aborted.
        if (abort || !r_scan) begin
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StDwell;
        end
      end
      StDwell: begin
        if (abort) begin
          w_state_nxt = StIdle;
        end else if (r_dwell_cnt <= 8'd1) begin
          w_state_nxt = (r_fn == 2'd3) ? StIdle : StSettle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (r_state != StIdle);
    unit_num  = r_unit;
    res_dig   = r_res_dig;
    res_sign  = r_res_sign;
    res_op    = r_res_op;
    res_valid = r_res_valid;
    err       = r_err;
  end

  // Result selection; F digits blank the unused display positions.
  always_comb begin
    w_cap_dig  = sqrt_dig;
    w_cap_sign = 1'b0;
    unique case (r_fn)
      2'd0: begin
        w_cap_dig  = {4'hF, sin_dig};
        w_cap_sign = sin_sign;
      end
      2'd1: begin
        w_cap_dig  = {8'hFF, cos_dig};
        w_cap_sign = cos_sign;
      end
      2'd2: begin
        w_cap_dig  = sqrt_dig;
        w_cap_sign = 1'b0;
      end
      2'd3: begin
        w_cap_dig  = {16'hFFFF, 3'b000, is_prime};
        w_cap_sign = 1'b0;
      end
      default: begin
        w_cap_dig  = sqrt_dig;
        w_cap_sign = 1'b0;
      end
    endcase
  end

  // Datapath and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt <= 4'd0;
      r_dwell_cnt  <= 8'd0;
      r_fn         <= 2'd0;
      r_scan       <= 1'b0;
      r_unit       <= 9'd0;
      r_res_dig    <= 20'd0;
      r_res_sign   <= 1'b0;
      r_res_op     <= 2'd0;
      r_res_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_err       <= w_illegal;

      if (w_accept) begin
        r_unit <= num_in;
        r_scan <= (op == 3'd4);
        r_fn   <= (op == 3'd4) ? 2'd0 : op[1:0];
      end

      if (w_load_settle) begin
        r_settle_cnt <= SettleLd;
      end else if (r_state == StSettle) begin
        r_settle_cnt <= r_settle_cnt - 4'd1;
      end

      if (w_load_dwell) begin
        r_dwell_cnt <= DwellLd;
      end else if (r_state == StDwell) begin
        r_dwell_cnt <= r_dwell_cnt - 8'd1;
      end

      if (r_state == StCapture) begin
        r_res_dig   <= w_cap_dig;
        r_res_sign  <= w_cap_sign;
        r_res_op    <= r_fn;
        r_res_valid <= 1'b1;
      end

      if ((r_state == StDwell) && (w_state_nxt == StSettle)) begin
        r_fn <= r_fn + 2'd1;
      end
    end
  end

endmodule
